fp_mul_pipe: RTL



---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_round_rne.sv | 23 ++
 rtl/fp_mul_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_NORM = 3'd1,
    CLS_INF  = 3'd2,
    CLS_QNAN = 3'd3,
    CLS_SNAN = 3'd4
  } fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN in the low 1+exp_w+man_w bits: exponent all ones, fraction MSB set.
  function automatic logic [127:0] fp_canon_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = {128{1'b0}};
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a fraction given its guard and sticky bits.
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] i_frac,
  input  logic             i_guard,
  input  logic             i_sticky,
  output logic [MAN_W-1:0] o_frac,
  output logic             o_carry,
  output logic             o_inexact
);

  logic             w_round_up;
  logic [MAN_W:0]   w_sum;

  // Exact ties round up only when the kept LSB is odd.
  assign w_round_up = i_guard & (i_sticky | i_frac[0]);
  assign w_sum      = {1'b0, i_frac} + {{MAN_W{1'b0}}, w_round_up};
  assign o_frac     = w_sum[MAN_W-1:0];
  assign o_carry    = w_sum[MAN_W];
  assign o_inexact  = i_guard | i_sticky;

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready backpressure,
// RNE rounding, flush-to-zero/DAZ, special-value handling and exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [EXP_W+MAN_W:0]     i_in_a,
  input  logic [EXP_W+MAN_W:0]     i_in_b,
  input  logic [TAG_W-1:0]         i_in_tag,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [EXP_W+MAN_W:0]     o_out_result,
  output logic [TAG_W-1:0]         o_out_tag,
  output logic [3:0]               o_out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
  localparam logic [127:0]         QNAN_FULL = fp_canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];

  function automatic fp_class_e classify(input logic [W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = v[W-2:MAN_W];
    f = v[MAN_W-1:0];
    if (e == {EXP_W{1'b0}})       return CLS_ZERO;
    else if (e != {EXP_W{1'b1}})  return CLS_NORM;
    else if (f == {MAN_W{1'b0}})  return CLS_INF;
    else if (f[MAN_W-1])          return CLS_QNAN;
    else                          return CLS_SNAN;
  endfunction

  logic w_stall;
  logic r_out_valid;

  assign w_stall    = r_out_valid & ~i_out_ready;
  assign o_in_ready = ~w_stall;

  // ---------------- S1: unpack, classify, exponent sum, mantissa product
  logic signed [XW-1:0] w_exp_sum;
  logic [PW-1:0]        w_prod;

  assign w_exp_sum = $signed({2'b00, i_in_a[W-2:MAN_W]}) + $signed({2'b00, i_in_b[W-2:MAN_W]}) - BIAS;
  assign w_prod    = PW'({1'b1, i_in_a[MAN_W-1:0]}) * PW'({1'b1, i_in_b[MAN_W-1:0]});

  logic                 r1_valid, r1_sign;
  logic signed [XW-1:0] r1_exp;
  logic [PW-1:0]        r1_prod;
  fp_class_e            r1_cls_a, r1_cls_b;
  logic [TAG_W-1:0]     r1_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_exp   <= {XW{1'b0}};
      r1_prod  <= {PW{1'b0}};
      r1_cls_a <= CLS_ZERO;
      r1_cls_b <= CLS_ZERO;
      r1_tag   <= {TAG_W{1'b0}};
    end else if (!w_stall) begin
      r1_valid <= i_in_valid;
      r1_sign  <= i_in_a[W-1] ^ i_in_b[W-1];
      r1_exp   <= w_exp_sum;
      r1_prod  <= w_prod;
      r1_cls_a <= classify(i_in_a);
      r1_cls_b <= classify(i_in_b);
      r1_tag   <= i_in_tag;
    end
  end

  // ---------------- S2: normalise so the leading one sits at PW-1, then round
  logic                 w_msb;
  logic [PW-1:0]        w_norm;
  logic [MAN_W-1:0]     w_frac_rnd;
  logic                 w_carry, w_inexact;
  logic signed [XW-1:0] w_exp2;

  assign w_msb  = r1_prod[PW-1];
  assign w_norm = w_msb ? r1_prod : {r1_prod[PW-2:0], 1'b0};

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .i_frac    (w_norm[PW-2:MAN_W+1]),
    .i_guard   (w_norm[MAN_W]),
    .i_sticky  (|w_norm[MAN_W-1:0]),
    .o_frac    (w_frac_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  assign w_exp2 = r1_exp + $signed({{(XW-1){1'b0}}, w_msb}) + $signed({{(XW-1){1'b0}}, w_carry});

  logic                 r2_valid, r2_sign, r2_inexact;
  logic signed [XW-1:0] r2_exp;
  logic [MAN_W-1:0]     r2_frac;
  fp_class_e            r2_cls_a, r2_cls_b;
  logic [TAG_W-1:0]     r2_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_valid   <= 1'b0;
      r2_sign    <= 1'b0;
      r2_inexact <= 1'b0;
      r2_exp     <= {XW{1'b0}};
      r2_frac    <= {MAN_W{1'b0}};
      r2_cls_a   <= CLS_ZERO;
      r2_cls_b   <= CLS_ZERO;
      r2_tag     <= {TAG_W{1'b0}};
    end else if (!w_stall) begin
      r2_valid   <= r1_valid;
      r2_sign    <= r1_sign;
      r2_inexact <= w_inexact;
      r2_exp     <= w_exp2;
      r2_frac    <= w_frac_rnd;
      r2_cls_a   <= r1_cls_a;
      r2_cls_b   <= r1_cls_b;
      r2_tag     <= r1_tag;
    end
  end

  // ---------------- S3: special-case priority mux, range check, pack
  logic         w_any_nan, w_any_snan, w_any_inf, w_any_zero;
  logic [W-1:0] w_res;
  logic [3:0]   w_flags;

  assign w_any_snan = (r2_cls_a == CLS_SNAN) | (r2_cls_b == CLS_SNAN);
  assign w_any_nan  = w_any_snan | (r2_cls_a == CLS_QNAN) | (r2_cls_b == CLS_QNAN);
  assign w_any_inf  = (r2_cls_a == CLS_INF)  | (r2_cls_b == CLS_INF);
  assign w_any_zero = (r2_cls_a == CLS_ZERO) | (r2_cls_b == CLS_ZERO);

  always_comb begin
    w_res   = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
    w_flags = 4'b0000;
    if (w_any_nan) begin
      w_res                 = QNAN;
      w_flags[FLAG_INVALID] = w_any_snan;
    end else if (w_any_inf && w_any_zero) begin
      w_res                 = QNAN;
      w_flags[FLAG_INVALID] = 1'b1;
    end else if (w_any_inf) begin
      w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_any_zero) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
    end else if (r2_exp >= EXP_MAX) begin
      w_res                  = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags[FLAG_OVERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]  = 1'b1;
    end else if (r2_exp <= EXP_ZERO) begin
      w_res                   = {r2_sign, {(W-1){1'b0}}};
      w_flags[FLAG_UNDERFLOW] = 1'b1;
      w_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      w_flags[FLAG_INEXACT] = r2_inexact;
    end
  end

  logic [W-1:0]     r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic [3:0]       r_out_flags;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {W{1'b0}};
      r_out_tag    <= {TAG_W{1'b0}};
      r_out_flags  <= 4'b0000;
    end else if (!w_stall) begin
      r_out_valid  <= r2_valid;
      r_out_result <= w_res;
      r_out_tag    <= r2_tag;
      r_out_flags  <= w_flags;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_out_tag    = r_out_tag;
  assign o_out_flags  = r_out_flags;

endmodule
